// File: rtl/pcie_link_monitor_pkg.sv
// Shared types, reset value and helpers for the PCIe link monitor.
// Counters are held at a fixed maximum width; the top slices them to CNT_WIDTH.
package pcie_link_monitor_pkg;

  localparam int CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_DOWN      = 2'd0,
    ST_UP_PEND   = 2'd1,
    ST_UP        = 2'd2,
    ST_DOWN_PEND = 2'd3
  } lnk_state_t;

  typedef struct packed {
    lnk_state_t           state;
    logic [15:0]          dbg_cnt;
    logic                 lnk_up;
    logic [7:0]           bus;
    logic [4:0]           dev;
    logic [2:0]           func;
    logic [CNT_MAX_W-1:0] up_cnt;
    logic [CNT_MAX_W-1:0] down_cnt;
    logic                 lnk_change;
    logic                 bdf_changed;
  } mon_regs_t;

  localparam mon_regs_t MON_RESET = '{state: ST_DOWN, default: '0};

  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] value,
                                                   input logic [CNT_MAX_W-1:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pcie_link_monitor.sv
// Debounces the PCIe core link-up signal, captures BDF while the link is up
// and keeps saturating up/down transition counters.
module pcie_link_monitor
  import pcie_link_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_user_lnk_up,
  input  logic [7:0]           i_cfg_bus_number,
  input  logic [4:0]           i_cfg_device_number,
  input  logic [2:0]           i_cfg_function_number,
  input  logic                 i_clr_cnt,
  output logic                 o_lnk_up,
  output logic [7:0]           o_cfg_bus_number,
  output logic [4:0]           o_cfg_device_number,
  output logic [2:0]           o_cfg_function_number,
  output logic                 o_bdf_changed,
  output logic                 o_lnk_change,
  output logic [CNT_WIDTH-1:0] o_up_cnt,
  output logic [CNT_WIDTH-1:0] o_down_cnt
);

  localparam logic [15:0] DBG_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_MAX_W-1:0] CNT_SAT = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - CNT_WIDTH);

  mon_regs_t state_reg;
  mon_regs_t state_next;
  logic      up_edge;
  logic      down_edge;
  logic      bdf_diff;

  assign bdf_diff = {i_cfg_bus_number, i_cfg_device_number, i_cfg_function_number}
                    != {state_reg.bus, state_reg.dev, state_reg.func};

  always_comb begin
    state_next             = state_reg;
    state_next.lnk_change  = 1'b0;
    state_next.bdf_changed = 1'b0;

    case (state_reg.state)
      ST_DOWN: begin
        if (i_user_lnk_up) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next.state = ST_UP;
          end else begin
            state_next.state   = ST_UP_PEND;
            state_next.dbg_cnt = 16'd1;
          end
        end
      end
      ST_UP_PEND: begin
        if (!i_user_lnk_up) begin
          state_next.state   = ST_DOWN;
          state_next.dbg_cnt = '0;
        end else if (state_reg.dbg_cnt == DBG_LAST) begin
          state_next.state   = ST_UP;
          state_next.dbg_cnt = '0;
        end else begin
          state_next.dbg_cnt = state_reg.dbg_cnt + 16'd1;
        end
      end
      ST_UP: begin
        if (!i_user_lnk_up) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next.state = ST_DOWN;
          end else begin
            state_next.state   = ST_DOWN_PEND;
            state_next.dbg_cnt = 16'd1;
          end
        end
      end
      ST_DOWN_PEND: begin
        if (i_user_lnk_up) begin
          state_next.state   = ST_UP;
          state_next.dbg_cnt = '0;
        end else if (state_reg.dbg_cnt == DBG_LAST) begin
          state_next.state   = ST_DOWN;
          state_next.dbg_cnt = '0;
        end else begin
          state_next.dbg_cnt = state_reg.dbg_cnt + 16'd1;
        end
      end
      default: begin
        state_next.state   = ST_DOWN;
        state_next.dbg_cnt = '0;
      end
    endcase

    // Debounced level is a pure function of the next state, so edges fall out
    // of comparing it with the current registered level.
    state_next.lnk_up = (state_next.state == ST_UP) || (state_next.state == ST_DOWN_PEND);
    up_edge           = state_next.lnk_up && !state_reg.lnk_up;
    down_edge         = !state_next.lnk_up && state_reg.lnk_up;
    state_next.lnk_change = up_edge || down_edge;

    if (i_clr_cnt) begin
      state_next.up_cnt   = '0;
      state_next.down_cnt = '0;
    end
    if (up_edge) begin
      state_next.up_cnt = sat_inc(i_clr_cnt ? '0 : state_reg.up_cnt, CNT_SAT);
    end
    if (down_edge) begin
      state_next.down_cnt = sat_inc(i_clr_cnt ? '0 : state_reg.down_cnt, CNT_SAT);
    end

    // A glitch back from DOWN_PEND is not a link-up event, so only a real
    // up edge or a change seen while stably up captures the BDF.
    if (down_edge) begin
      state_next.bus  = '0;
      state_next.dev  = '0;
      state_next.func = '0;
    end else if (up_edge || (state_reg.state == ST_UP && bdf_diff)) begin
      state_next.bus         = i_cfg_bus_number;
      state_next.dev         = i_cfg_device_number;
      state_next.func        = i_cfg_function_number;
      state_next.bdf_changed = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= MON_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  assign o_lnk_up              = state_reg.lnk_up;
  assign o_cfg_bus_number      = state_reg.bus;
  assign o_cfg_device_number   = state_reg.dev;
  assign o_cfg_function_number = state_reg.func;
  assign o_bdf_changed         = state_reg.bdf_changed;
  assign o_lnk_change          = state_reg.lnk_change;
  assign o_up_cnt              = state_reg.up_cnt[CNT_WIDTH-1:0];
  assign o_down_cnt            = state_reg.down_cnt[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_pcie_link_monitor.sv
// Directed and randomized checks of pcie_link_monitor against a run-length
// reference model of the debounce, BDF capture and counter rules.
module tb_pcie_link_monitor;

  localparam int DEB  = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic          raw;
  logic [7:0]    bus_in;
  logic [4:0]    dev_in;
  logic [2:0]    func_in;
  logic          clr;
  logic          o_lnk_up;
  logic [7:0]    o_bus;
  logic [4:0]    o_dev;
  logic [2:0]    o_func;
  logic          o_bdf_changed;
  logic          o_lnk_change;
  logic [CW-1:0] o_up_cnt;
  logic [CW-1:0] o_down_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: debounced level flips after DEB consecutive differing samples.
  bit       m_lnk;
  int       m_run;
  bit       m_chg;
  bit       m_bchg;
  logic [7:0] m_bus;
  logic [4:0] m_dev;
  logic [2:0] m_func;
  int       m_up;
  int       m_down;

  always #5 clk = ~clk;

  pcie_link_monitor #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)) dut (
    .i_clk                 (clk),
    .i_nrst                (nrst),
    .i_user_lnk_up         (raw),
    .i_cfg_bus_number      (bus_in),
    .i_cfg_device_number   (dev_in),
    .i_cfg_function_number (func_in),
    .i_clr_cnt             (clr),
    .o_lnk_up              (o_lnk_up),
    .o_cfg_bus_number      (o_bus),
    .o_cfg_device_number   (o_dev),
    .o_cfg_function_number (o_func),
    .o_bdf_changed         (o_bdf_changed),
    .o_lnk_change          (o_lnk_change),
    .o_up_cnt              (o_up_cnt),
    .o_down_cnt            (o_down_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lnk = 0; m_run = 0; m_chg = 0; m_bchg = 0;
    m_bus = '0; m_dev = '0; m_func = '0;
    m_up = 0; m_down = 0;
  endtask

  task automatic model_step();
    bit was_up;
    was_up = m_lnk && (m_run == 0);
    m_chg  = 0;
    m_bchg = 0;
    if (raw != m_lnk) m_run++;
    else m_run = 0;
    if (clr) begin
      m_up = 0;
      m_down = 0;
    end
    if (m_run == DEB) begin
      m_run = 0;
      m_lnk = !m_lnk;
      m_chg = 1;
      if (m_lnk) begin
        m_up = (m_up < CMAX) ? m_up + 1 : CMAX;
        m_bus = bus_in; m_dev = dev_in; m_func = func_in;
        m_bchg = 1;
      end else begin
        m_down = (m_down < CMAX) ? m_down + 1 : CMAX;
        m_bus = '0; m_dev = '0; m_func = '0;
      end
    end else if (was_up && ({bus_in, dev_in, func_in} != {m_bus, m_dev, m_func})) begin
      m_bus = bus_in; m_dev = dev_in; m_func = func_in;
      m_bchg = 1;
    end
  endtask

  task automatic check_all();
    chk("lnk_up",      32'(o_lnk_up),      32'(m_lnk));
    chk("lnk_change",  32'(o_lnk_change),  32'(m_chg));
    chk("bdf_changed", 32'(o_bdf_changed), 32'(m_bchg));
    chk("bus",         32'(o_bus),         32'(m_bus));
    chk("dev",         32'(o_dev),         32'(m_dev));
    chk("func",        32'(o_func),        32'(m_func));
    chk("up_cnt",      32'(o_up_cnt),      32'(m_up));
    chk("down_cnt",    32'(o_down_cnt),    32'(m_down));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  initial begin
    nrst = 1'b0; raw = 1'b0; clr = 1'b0;
    bus_in = 8'h00; dev_in = 5'h00; func_in = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all();
    nrst = 1'b1;
    $display("[TB] reset state checked");

    // Short glitch from down must be absorbed.
    repeat (4) tick();
    raw = 1'b1;
    repeat (5) tick();
    raw = 1'b0;
    repeat (20) tick();
    chk("glitch_lnk", 32'(o_lnk_up), 32'd0);
    chk("glitch_up_cnt", 32'(o_up_cnt), 32'd0);
    $display("[TB] 5-cycle glitch from down");

    // Clean edge: 15 samples are not enough, the 16th flips the level.
    raw = 1'b1;
    repeat (15) tick();
    chk("edge_lnk_early", 32'(o_lnk_up), 32'd0);
    tick();
    chk("edge_lnk", 32'(o_lnk_up), 32'd1);
    chk("edge_change", 32'(o_lnk_change), 32'd1);
    chk("edge_up_cnt", 32'(o_up_cnt), 32'd1);
    chk("edge_func", 32'(o_func), 32'd2);
    tick();
    chk("edge_change_off", 32'(o_lnk_change), 32'd0);
    $display("[TB] clean up edge");

    bus_in = 8'h03;
    tick();
    chk("bus_follow", 32'(o_bus), 32'h03);
    chk("bus_pulse", 32'(o_bdf_changed), 32'd1);
    tick();
    chk("bus_pulse_off", 32'(o_bdf_changed), 32'd0);
    dev_in = 5'h1F;
    tick();
    chk("dev_follow", 32'(o_dev), 32'h1F);
    chk("dev_pulse", 32'(o_bdf_changed), 32'd1);
    tick();
    $display("[TB] BDF updates while up");

    raw = 1'b0;
    repeat (15) tick();
    chk("drop_lnk_early", 32'(o_lnk_up), 32'd1);
    tick();
    chk("drop_lnk", 32'(o_lnk_up), 32'd0);
    chk("drop_bus", 32'(o_bus), 32'd0);
    chk("drop_dev", 32'(o_dev), 32'd0);
    chk("drop_down_cnt", 32'(o_down_cnt), 32'd1);
    chk("drop_no_bdf_pulse", 32'(o_bdf_changed), 32'd0);
    $display("[TB] link drop");

    // Clear coinciding with an up transition.
    raw = 1'b1;
    repeat (15) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_edge_up", 32'(o_up_cnt), 32'd1);
    chk("clr_edge_down", 32'(o_down_cnt), 32'd0);
    raw = 1'b0;
    repeat (16) tick();
    $display("[TB] clear coincident with up edge");

    // Asynchronous reset in the middle of an up-pending count.
    repeat (4) tick();
    raw = 1'b1;
    repeat (8) tick();
    nrst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_up_cnt", 32'(o_up_cnt), 32'd0);
    chk("rst_down_cnt", 32'(o_down_cnt), 32'd0);
    #2;
    nrst = 1'b1;
    repeat (15) tick();
    chk("rst_relock_early", 32'(o_lnk_up), 32'd0);
    tick();
    chk("rst_relock", 32'(o_lnk_up), 32'd1);
    raw = 1'b0;
    repeat (16) tick();
    $display("[TB] async reset mid debounce");

    for (int n = 0; n < 20; n++) begin
      raw = 1'b1;
      repeat (16) tick();
      raw = 1'b0;
      repeat (16) tick();
    end
    chk("sat_up", 32'(o_up_cnt), 32'd15);
    chk("sat_down", 32'(o_down_cnt), 32'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sat_clr_up", 32'(o_up_cnt), 32'd0);
    chk("sat_clr_down", 32'(o_down_cnt), 32'd0);
    $display("[TB] counter saturation and clear");

    // Random runs of raw level with sporadic BDF changes and clears.
    for (int r = 0; r < 40; r++) begin
      int len;
      raw = ~raw;
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          bus_in  = 8'($urandom);
          dev_in  = 5'($urandom);
          func_in = 3'($urandom);
        end
        clr = ($urandom_range(0, 31) == 0);
        tick();
      end
      clr = 1'b0;
    end
    $display("[TB] randomized runs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pcie_link_monitor.md
Name: pcie_link_monitor

Overview:
- Sits between the PCIe hard-IP user interface and the APB PCIe register block; feeds it a debounced link state, the captured bus/device/function, and event statistics.
- Filters glitches on the raw link-up signal and tracks link-up/link-down transitions with saturating counters.
- Raises a single-cycle change pulse for interrupt or status logic.
- Runs entirely in the PCIe user clock domain.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a raw level must hold before the debounced state changes; legal range 1..65535.
- CNT_WIDTH, 16: width of the event counters.

Ports:
- i_clk  in  1  PCIe user clock
- i_nrst  in  1  asynchronous active-low reset
- i_user_lnk_up  in  1  raw link-up from the PCIe core
- i_cfg_bus_number  in  8  bus number from the core
- i_cfg_device_number  in  5  device number from the core
- i_cfg_function_number  in  3  function number from the core
- i_clr_cnt  in  1  one-cycle pulse that clears both event counters
- o_lnk_up  out  1  debounced link state
- o_cfg_bus_number  out  8  captured bus number
- o_cfg_device_number  out  5  captured device number
- o_cfg_function_number  out  3  captured function number
- o_bdf_changed  out  1  one-cycle pulse when the captured BDF updates
- o_lnk_change  out  1  one-cycle pulse on each debounced transition
- o_up_cnt  out  CNT_WIDTH  count of debounced up transitions
- o_down_cnt  out  CNT_WIDTH  count of debounced down transitions

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; state ST_DOWN; debounce counter 0.
- FSM states: ST_DOWN, ST_UP_PEND, ST_UP, ST_DOWN_PEND.
  - ST_DOWN, raw=1: go to ST_UP_PEND, dbg_cnt=1.
  - ST_UP_PEND, raw=0: return to ST_DOWN, dbg_cnt=0.
  - ST_UP_PEND, raw=1 and dbg_cnt==DEBOUNCE_CYCLES-1: go to ST_UP. Otherwise increment dbg_cnt.
  - ST_UP, raw=0: go to ST_DOWN_PEND, dbg_cnt=1.
  - ST_DOWN_PEND: mirror of ST_UP_PEND. Raw=1 returns to ST_UP; after the full count, go to ST_DOWN.
- Special case DEBOUNCE_CYCLES=1: the PEND states are skipped and the transition happens on the first sampled cycle.
- Output timing:
  - o_lnk_up is registered; it is 1 in ST_UP and ST_DOWN_PEND, else 0.
  - With a clean edge at cycle T, o_lnk_up changes at the clock edge ending cycle T+DEBOUNCE_CYCLES-1; it is visible in cycle T+DEBOUNCE_CYCLES.
- o_lnk_change: pulses 1 in the same cycle that o_lnk_up first shows its new value.
- Counters:
  - o_up_cnt / o_down_cnt increment on the matching transition and saturate at all-ones (no wrap).
  - i_clr_cnt zeroes both counters.
  - If i_clr_cnt coincides with a transition, the result is 1 for the transitioning counter and 0 for the other.
- BDF capture:
  - On the transition into ST_UP, the BDF inputs are latched.
  - While in ST_UP, any cycle where the inputs differ from the latched value relatches them.
  - Each capture makes o_bdf_changed pulse in the cycle after the inputs are registered.
  - BDF inputs are ignored in all other states.
  - On the transition into ST_DOWN, the captured BDF clears to 0 with no o_bdf_changed pulse.
- Glitches shorter than DEBOUNCE_CYCLES produce no output change, no pulse, and no count.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Counters are lost.

Decomposition:
- Shared package pcie_link_monitor_pkg holds:
  - state enum (2 bits);
  - a register struct {state, dbg_cnt[15:0], lnk_up, bus, dev, func, up_cnt, down_cnt, lnk_change, bdf_changed};
  - a reset constant of that struct, all zero with state ST_DOWN.
- Single always_comb next-state plus always_ff register process; no sub-module needed.
- The saturating counter may be a function in the package.

Test Plan:
- DEBOUNCE_CYCLES=16: raw goes 0->1 at cycle 10 and holds -> o_lnk_up=1 from cycle 26; o_lnk_change pulses at cycle 26; o_up_cnt=1.
- Raw 1-pulse of 5 cycles from ST_DOWN -> o_lnk_up stays 0, no pulse, o_up_cnt=0.
- While up, bus changes 0x00->0x03 and device 0->0x1F -> captured outputs follow one cycle later with one o_bdf_changed pulse per change. Link drop for 16 cycles -> BDF=0, o_down_cnt=1.
- CNT_WIDTH=4, 20 full up/down cycles -> o_up_cnt=o_down_cnt=15 (saturated). Then i_clr_cnt -> both 0.
- i_clr_cnt in the same cycle as an up transition -> o_up_cnt=1, o_down_cnt=0.
- i_nrst pulled low during ST_UP_PEND at dbg_cnt=8 -> all outputs 0 immediately. After release, a full 16 cycles of raw=1 are required before o_lnk_up=1.
